// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encodings
// and default parameter values.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT       = 16;
  localparam int WAIT_CNT_W          = 8;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count, held once all-ones is reached
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: Mealy FSM arbitrating memory waits,
// taken branches and RAW hazards, plus saturating performance counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_all,
  output logic             mem_timeout_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] hazard_stalls,
  output logic [CNT_W-1:0] mem_stalls,
  output logic [CNT_W-1:0] flushes
);

  state_e                  state_q, state_d, decode_state_s;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    pass_s;
  logic                    hazard_inc_s;
  logic                    mem_inc_s;

  // next state and Mealy outputs; while rst is high decode as RUN with memory masked
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pass_s          = 1'b0;
    hazard_inc_s    = 1'b0;
    mem_inc_s       = 1'b0;
    freeze_pc       = 1'b0;
    freeze_if_id    = 1'b0;
    flush_if_id     = 1'b0;
    bubble_id_exe   = 1'b0;
    freeze_all      = 1'b0;
    mem_timeout_err = 1'b0;
    decode_state_s  = rst ? ST_RUN : state_q;

    case (decode_state_s)
      ST_RUN: begin
        if (mem_req && !mem_ready && !rst) begin
          freeze_all = 1'b1;
          mem_inc_s  = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          pass_s = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // ready wins over a timeout in the same cycle
        if (mem_ready) begin
          pass_s  = 1'b1;
          state_d = ST_RUN;
        end else begin
          freeze_all = 1'b1;
          mem_inc_s  = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      default: begin
        freeze_all      = 1'b1;
        mem_timeout_err = 1'b1;
        state_d         = ST_ERROR;
      end
    endcase

    // branch beats hazard: the hazarding instruction is on the wrong path
    if (pass_s && branch_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (pass_s && hazard_detected) begin
      freeze_pc     = 1'b1;
      freeze_if_id  = 1'b1;
      bubble_id_exe = 1'b1;
      hazard_inc_s  = 1'b1;
    end else begin
      hazard_inc_s  = 1'b0;
    end
  end

  // FSM state and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_hazard_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hazard_inc_s),
    .count (hazard_stalls)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_inc_s),
    .count (mem_stalls)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_if_id),
    .count (flushes)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench: two controller instances (defaults, and
// MEM_TIMEOUT=4/CNT_W=4) share stimulus; expectations are queued then checked.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_req, mem_ready;

  logic a_fpc, a_fifid, a_flush, a_bub, a_fall, a_err;
  logic [1:0]  a_state;
  logic [15:0] a_hz, a_ms, a_fl;
  logic b_fpc, b_fifid, b_flush, b_bub, b_fall, b_err;
  logic [1:0]  b_state;
  logic [3:0]  b_hz, b_ms, b_fl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_stall_controller dut_a (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(a_fpc), .freeze_if_id(a_fifid), .flush_if_id(a_flush),
    .bubble_id_exe(a_bub), .freeze_all(a_fall), .mem_timeout_err(a_err),
    .state(a_state), .hazard_stalls(a_hz), .mem_stalls(a_ms), .flushes(a_fl)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(b_fpc), .freeze_if_id(b_fifid), .flush_if_id(b_flush),
    .bubble_id_exe(b_bub), .freeze_all(b_fall), .mem_timeout_err(b_err),
    .state(b_state), .hazard_stalls(b_hz), .mem_stalls(b_ms), .flushes(b_fl)
  );

  // sel: 0/1 = control+state of A/B as {fpc,fifid,flush,bub,fall,err,state}
  //      2..4 = A hazard/mem/flush counters, 5..7 = B hazard/mem/flush counters
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       obs = {24'd0, a_fpc, a_fifid, a_flush, a_bub, a_fall, a_err, a_state};
      1:       obs = {24'd0, b_fpc, b_fifid, b_flush, b_bub, b_fall, b_err, b_state};
      2:       obs = {16'd0, a_hz};
      3:       obs = {16'd0, a_ms};
      4:       obs = {16'd0, a_fl};
      5:       obs = {28'd0, b_hz};
      6:       obs = {28'd0, b_ms};
      7:       obs = {28'd0, b_fl};
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drive(input logic h, input logic b, input logic mr,
                       input logic rdy, input logic r);
    @(negedge clk);
    hazard_detected = h; branch_taken = b; mem_req = mr; mem_ready = rdy; rst = r;
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("reset_ctl_a", 0, 32'h00); push("reset_ctl_b", 1, 32'h00);
    push("reset_hz_a", 2, 32'd0);   push("reset_ms_a", 3, 32'd0);
    push("reset_fl_a", 4, 32'd0);
    check_all();

    // two hazard cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push("hazard_ctl", 0, {24'd0, 6'b110100, 2'd0});
      check_all();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("hazard_idle_ctl", 0, 32'h00);
    push("hazard_stalls_2", 2, 32'd2);
    check_all();

    // branch with hazard: branch wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push("branch_ctl", 0, {24'd0, 6'b001100, 2'd0});
    check_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("branch_flushes", 4, 32'd1);
    push("branch_hz_unchanged", 2, 32'd2);
    check_all();

    // memory wait: 3 frozen cycles then ready together with a taken branch
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push("mem_run_ctl", 0, {24'd0, 6'b000010, 2'd0});
    check_all();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("mem_wait_ctl", 0, {24'd0, 6'b000010, 2'd1});
      check_all();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push("mem_ready_branch_ctl", 0, {24'd0, 6'b001100, 2'd1});
    check_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("mem_back_run", 0, 32'h00);
    push("mem_stalls_3", 3, 32'd3);
    push("mem_flushes_2", 4, 32'd2);
    check_all();

    // timeout on the MEM_TIMEOUT=4 instance: 5 frozen cycles then ERROR
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push("to_frozen_ctl_b", 1, {24'd0, 6'b000010, (i == 0) ? 2'd0 : 2'd1});
      check_all();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("to_error_ctl_b", 1, {24'd0, 6'b000011, 2'd2});
    push("to_error_a_still_wait", 0, {24'd0, 6'b000010, 2'd1});
    check_all();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push("error_sticky_ctl_b", 1, {24'd0, 6'b000011, 2'd2});
    push("error_mem_stalls_b", 6, 32'd8);
    check_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("error_sticky2_ctl_b", 1, {24'd0, 6'b000011, 2'd2});
    push("error_no_more_stalls_b", 6, 32'd8);
    check_all();

    // reset in the middle of MEM_WAIT (A) and ERROR (B)
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_all();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("pre_rst_wait_a", 0, {24'd0, 6'b000010, 2'd1});
    check_all();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push("in_rst_run_decode_a", 0, {24'd0, 6'b110100, 2'd1});
    check_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("post_rst_ctl_a", 0, 32'h00); push("post_rst_ctl_b", 1, 32'h00);
    push("post_rst_hz_a", 2, 32'd0);   push("post_rst_ms_a", 3, 32'd0);
    push("post_rst_fl_a", 4, 32'd0);   push("post_rst_ms_b", 6, 32'd0);
    push("post_rst_fl_b", 7, 32'd0);
    check_all();

    // saturation: 20 hazard cycles
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("sat_hz_b", 5, 32'd15);
    push("sat_hz_a", 2, 32'd20);
    check_all();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("sat_hold_b", 5, 32'd15);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
